// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter_if
//  Description : Signal bundle for the fetch/load-store/memory-bus arbiter.
//                'master' is the arbiter's view. It masters the memory bus
//                and serves both requesters. 'slave' is the surrounding
//                pipeline and memory view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if;
    // Instruction fetch port
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [31:0] inst_req_addr;
    logic        inst_resp_valid;
    logic        inst_resp_ready;
    logic [31:0] inst_resp_data;

    // Load/store port
    logic        data_req_valid;
    logic        data_req_ready;
    logic [31:0] data_req_addr;
    logic        data_req_wen;
    logic [3:0]  data_req_wstrb;
    logic [31:0] data_req_wdata;
    logic        data_resp_valid;
    logic        data_resp_ready;
    logic [31:0] data_resp_data;

    // Memory bus
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_wen;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_data;

    modport master (
        input  inst_req_valid, inst_req_addr, inst_resp_ready,
        output inst_req_ready, inst_resp_valid, inst_resp_data,
        input  data_req_valid, data_req_addr, data_req_wen, data_req_wstrb,
               data_req_wdata, data_resp_ready,
        output data_req_ready, data_resp_valid, data_resp_data,
        output bus_req_valid, bus_addr, bus_wen, bus_wstrb, bus_wdata,
        input  bus_req_ready, bus_resp_valid, bus_resp_data
    );

    modport slave (
        output inst_req_valid, inst_req_addr, inst_resp_ready,
        input  inst_req_ready, inst_resp_valid, inst_resp_data,
        output data_req_valid, data_req_addr, data_req_wen, data_req_wstrb,
               data_req_wdata, data_resp_ready,
        input  data_req_ready, data_resp_valid, data_resp_data,
        input  bus_req_valid, bus_addr, bus_wen, bus_wstrb, bus_wdata,
        output bus_req_ready, bus_resp_valid, bus_resp_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Single-outstanding arbiter between instruction fetch and
//                load/store onto one SRAM-like bus. Data has priority. Fetch
//                is forced through after STARVE_LIMIT consecutive data grants
//                taken while a fetch was waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_bus_arbiter_if.master  bus_if
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] c_starve_max = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_owner;        // 0 = fetch, 1 = load/store
    logic [31:0]   r_addr;
    logic          r_wen;
    logic [3:0]    r_wstrb;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [SW-1:0] r_starve;

    logic          w_starved;
    logic          w_grant_inst;
    logic          w_grant_data;
    logic          w_bus_req_valid;
    logic          w_inst_resp_valid;
    logic          w_data_resp_valid;

    assign w_starved = (r_starve == c_starve_max);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, grant decision and handshake outputs
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_inst      = 1'b0;
        w_grant_data      = 1'b0;
        w_bus_req_valid   = 1'b0;
        w_inst_resp_valid = 1'b0;
        w_data_resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Fetch wins only if data is absent or fetch has been starved
                if (bus_if.inst_req_valid && (!bus_if.data_req_valid || w_starved)) begin
                    w_grant_inst = 1'b1;
                    w_state_nxt  = S_REQ;
                end else if (bus_if.data_req_valid) begin
                    w_grant_data = 1'b1;
                    w_state_nxt  = S_REQ;
                end
            end
            S_REQ: begin
                w_bus_req_valid = 1'b1;
                if (bus_if.bus_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_if.bus_resp_valid) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (r_owner) begin
                    w_data_resp_valid = 1'b1;
                    if (bus_if.data_resp_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_inst_resp_valid = 1'b1;
                    if (bus_if.inst_resp_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the granted request and capture the bus read data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_grant_inst) begin
                // Fetches are always reads; write fields are forced clear
                r_owner <= 1'b0;
                r_addr  <= bus_if.inst_req_addr;
                r_wen   <= 1'b0;
                r_wstrb <= '0;
                r_wdata <= '0;
            end else if (w_grant_data) begin
                r_owner <= 1'b1;
                r_addr  <= bus_if.data_req_addr;
                r_wen   <= bus_if.data_req_wen;
                r_wstrb <= bus_if.data_req_wstrb;
                r_wdata <= bus_if.data_req_wdata;
            end
            if ((r_state == S_WAIT) && bus_if.bus_resp_valid) begin
                r_rdata <= bus_if.bus_resp_data;
            end
        end
    end

    // Starvation counter: counts data grants that bypassed a waiting fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_grant_inst) begin
            r_starve <= '0;
        end else if (w_grant_data && bus_if.inst_req_valid && !w_starved) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    assign bus_if.inst_req_ready  = w_grant_inst;
    assign bus_if.data_req_ready  = w_grant_data;
    assign bus_if.inst_resp_valid = w_inst_resp_valid;
    assign bus_if.data_resp_valid = w_data_resp_valid;
    assign bus_if.inst_resp_data  = w_inst_resp_valid ? r_rdata : 32'd0;
    assign bus_if.data_resp_data  = w_data_resp_valid ? r_rdata : 32'd0;
    assign bus_if.bus_req_valid   = w_bus_req_valid;
    assign bus_if.bus_addr        = r_addr;
    assign bus_if.bus_wen         = r_wen;
    assign bus_if.bus_wstrb       = r_wstrb;
    assign bus_if.bus_wdata       = r_wdata;

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single SRAM-like memory bus between the IF-stage instruction fetch port and the MEM-stage load/store port. Accepts one request at a time using valid/ready handshakes on every side, issues it to the bus, waits for the bus response, and returns it to the requester that owns the transaction. Data requests have priority, with a starvation guard for fetch. Only one transaction is outstanding at a time.

## Interface
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending before fetch is forced to win (≥1)

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_req_valid  in  1  fetch request present
- inst_req_ready  out  1  fetch request accepted this cycle
- inst_req_addr  in  32  fetch address
- inst_resp_valid  out  1  fetch data available
- inst_resp_ready  in  1  IF consumes response
- inst_resp_data  out  32  fetched word
- data_req_valid  in  1  load/store request present
- data_req_ready  out  1  load/store accepted this cycle
- data_req_addr  in  32  data address
- data_req_wen  in  1  1 = store, 0 = load
- data_req_wstrb  in  4  byte enables for a store
- data_req_wdata  in  32  store data
- data_resp_valid  out  1  load data / store ack available
- data_resp_ready  in  1  MEM consumes response
- data_resp_data  out  32  load word; echoes bus data for stores
- bus_req_valid  out  1  request to memory
- bus_req_ready  in  1  memory accepts request
- bus_addr / bus_wen / bus_wstrb / bus_wdata  out  32/1/4/32  latched request fields
- bus_resp_valid  in  1  memory response strobe, single cycle
- bus_resp_data  in  32  memory read data

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Registers: state, owner (0 = inst, 1 = data), latched addr/wen/wstrb/wdata, response data, starve counter (width $clog2(STARVE_LIMIT+1)).
- IDLE: if any req_valid, grant one. Data wins unless starve == STARVE_LIMIT and inst_req_valid; then inst wins. The winner's req_ready = 1 in this cycle only. Latch its fields, with an inst grant forcing wen = 0 and wstrb = 0. Set owner and go to REQ.
- Starve counter: increments, saturating, on a data grant while inst_req_valid = 1. It clears on any inst grant. It is otherwise held.
- REQ: bus_req_valid = 1 with the latched fields held stable. On bus_req_ready go to WAIT.
- WAIT: bus_resp_valid captures bus_resp_data and moves to RESP.
- RESP: the owner's resp_valid = 1 and resp_data = the captured word. The other side's resp_valid = 0. On the owner's resp_ready go to IDLE.
- req_ready is 0 in every state other than IDLE. bus_resp_valid outside WAIT is ignored.
- Non-owner resp_data outputs are 0.

## Timing
- Reset: state = IDLE, starve = 0, owner = 0, all latched fields = 0. All outputs are 0.
- Reset mid-transaction drops the transaction and returns to IDLE next cycle. No response is delivered.
- Minimum latency with bus_req_ready tied high and a response on the first WAIT cycle:
  - cycle 0: accept
  - cycle 1: bus_req_valid
  - cycle 2: bus_resp_valid
  - cycle 3: resp_valid
  - cycle 4: earliest next accept
- req_ready is a combinational function of state, starve and both req_valid inputs. No output depends combinationally on bus_req_ready, bus_resp_valid or resp_ready.
- Bus fields are held unchanged from REQ entry until bus_req_ready.
- A response stalled in RESP holds resp_valid and resp_data stable.
- Simultaneous inst and data valid in IDLE: exactly one ready is asserted, never both.

## Test plan
- Single load: data_req addr 0x100, bus returns 0xDEADBEEF one cycle after acceptance -> data_resp_valid at cycle 3 with 0xDEADBEEF, inst side silent.
- Store: wen = 1, wstrb = 0x3, wdata = 0x1234ABCD, addr 0x200 -> bus_addr 0x200, bus_wen 1, bus_wstrb 0x3, bus_wdata 0x1234ABCD, stable until bus_req_ready. Ack then returned on data_resp.
- Contention with STARVE_LIMIT = 4: both valid continuously -> grant order D, D, D, D, I, D, D, D, D, I. Counter clears after each I.
- Backpressure: bus_req_ready low 5 cycles, then data_resp_ready low 3 cycles -> fields and resp stable throughout. No new req_ready until handshake completes.
- Reset during WAIT, then stray bus_resp_valid -> no resp_valid, all outputs 0, next fetch at 0x0 served normally.
